awg_seq: RTL and testbench

Parametrised arbitrary waveform generator with explicit playback sequencing. Holds a 2**PTBITS-entry sample table written through a dedicated port. Plays entries 0..last_addr either continuously or as a triggered one-shot burst, at one sample per (pre+1) clocks, or passes a direct value through. Drives one DAC channel of the acquisition/stimulus front end and exports sync/done strobes for scope triggering.

---
 rtl/awg_seq.sv | 148 ++++++++++++++
 tb/tb_awg_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_seq.sv
// awg_seq: table-driven arbitrary waveform generator.
// Plays a sample table continuously or as a one-shot burst.
module awg_seq #(
  parameter int NBITS   = 12,
  parameter int PTBITS  = 10,
  parameter int PREBITS = 16
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PTBITS-1:0]  wr_addr,
  input  logic [NBITS-1:0]   wr_data,
  input  logic [NBITS-1:0]   din,
  input  logic [1:0]         mode,
  input  logic [PREBITS-1:0] pre,
  input  logic [PTBITS-1:0]  last_addr,
  input  logic               trig,
  input  logic               stop,
  output logic [NBITS-1:0]   out,
  output logic               busy,
  output logic               sync,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_CONT   = 2'b01;
  localparam logic [1:0] M_ONE    = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  localparam logic [PTBITS-1:0]  A_ONE = 1;
  localparam logic [PREBITS-1:0] C_ONE = 1;

  logic [NBITS-1:0] mem [2**PTBITS];

  state_e             state_q, state_d;
  logic [PTBITS-1:0]  raddr_q, raddr_d;
  logic [PREBITS-1:0] cnt_q, cnt_d;
  logic [PREBITS-1:0] pre_l_q, pre_l_d;
  logic [PTBITS-1:0]  last_l_q, last_l_d;
  logic [NBITS-1:0]   rd_q, rd_d;
  logic               v1_q, v1_d;
  logic               sync1_q, sync1_d;
  logic               done1_q, done1_d;
  logic [NBITS-1:0]   out_q, out_d;
  logic               sync_q, sync_d;
  logic               done_q, done_d;

  logic hold, direct, play, flush, run, at_end;

  // Table has no reset so its contents survive rst.
  always_ff @(posedge ck) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    hold   = (mode == M_HOLD);
    direct = (mode == M_DIRECT);
    play   = (mode == M_CONT) || (mode == M_ONE);
    flush  = direct || stop;
    run    = (state_q == RUN);
    at_end = (cnt_q == pre_l_q) && (raddr_q == last_l_q);

    state_d  = state_q;
    raddr_d  = raddr_q;
    cnt_d    = cnt_q;
    pre_l_d  = pre_l_q;
    last_l_d = last_l_q;
    rd_d     = rd_q;
    v1_d     = v1_q;
    sync1_d  = sync1_q;
    done1_d  = done1_q;
    out_d    = out_q;
    sync_d   = 1'b0;
    done_d   = 1'b0;

    if (!hold) begin
      rd_d    = mem[raddr_q];
      v1_d    = run && !flush;
      sync1_d = run && !flush && (raddr_q == '0) && (cnt_q == '0);
      done1_d = run && !flush && !trig && (mode == M_ONE) && at_end;
      sync_d  = sync1_q && !flush;
      done_d  = done1_q && !flush;

      if (direct)           out_d = din;
      else if (v1_q && !stop) out_d = rd_q;

      if (flush) begin
        state_d = IDLE;
      end else if (trig && play) begin
        state_d  = RUN;
        pre_l_d  = pre;
        last_l_d = last_addr;
        raddr_d  = '0;
        cnt_d    = '0;
      end else if (run) begin
        if (cnt_q == pre_l_q) begin
          cnt_d = '0;
          if (raddr_q == last_l_q) begin
            if (mode == M_ONE) state_d = IDLE;
            else               raddr_d = '0;
          end else begin
            raddr_d = raddr_q + A_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= IDLE;
      raddr_q  <= '0;
      cnt_q    <= '0;
      pre_l_q  <= '0;
      last_l_q <= '0;
      rd_q     <= '0;
      v1_q     <= 1'b0;
      sync1_q  <= 1'b0;
      done1_q  <= 1'b0;
      out_q    <= '0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      cnt_q    <= cnt_d;
      pre_l_q  <= pre_l_d;
      last_l_q <= last_l_d;
      rd_q     <= rd_d;
      v1_q     <= v1_d;
      sync1_q  <= sync1_d;
      done1_q  <= done1_d;
      out_q    <= out_d;
      sync_q   <= sync_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign sync = sync_q;
  assign done = done_q;

endmodule

// File: tb/tb_awg_seq.sv
// tb_awg_seq: directed checks of awg_seq playback,
// sequencing, hold, direct mode, reset and table writes.
module tb_awg_seq;

  logic        ck = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic [11:0] din;
  logic [1:0]  mode;
  logic [15:0] pre;
  logic [9:0]  last_addr;
  logic        trig;
  logic        stop;
  logic [11:0] out;
  logic        busy;
  logic        sync;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [11:0] tab [4] = '{12'h100, 12'h200, 12'h300, 12'h400};

  awg_seq dut (
    .ck(ck), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .din(din), .mode(mode), .pre(pre),
    .last_addr(last_addr), .trig(trig), .stop(stop),
    .out(out), .busy(busy), .sync(sync), .done(done)
  );

  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    din = '0; mode = 2'b10; pre = '0; last_addr = '0;
    trig = 1'b0; stop = 1'b0;
    step(); step();
    checks++;
    if (out !== 12'h000 || busy !== 1'b0 || sync !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h busy=%b sync=%b done=%b want 000/0/0/0",
               out, busy, sync, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = tab[i];
      step();
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (out !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_load: out=%h busy=%b want 000/0", out, busy);
    end
  endtask

  task automatic test_oneshot();
    mode = 2'b10; pre = 16'd1; last_addr = 10'd3; trig = 1'b1;
    step();
    trig = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_busy_t0: busy=%b want 1", busy);
    end
    step(); step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out !== tab[i/2] || sync !== (i == 0) || done !== (i == 7)
          || busy !== ((2 + i) <= 7)) begin
        errors++;
        $display("FAIL oneshot[%0d]: out=%h sync=%b done=%b busy=%b want %h %b %b %b",
                 i, out, sync, done, busy, tab[i/2], i == 0, i == 7, (2 + i) <= 7);
      end
      step();
    end
    step();
    checks++;
    if (out !== 12'h400 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_tail: out=%h done=%b busy=%b want 400/0/0",
               out, done, busy);
    end
  endtask

  task automatic test_continuous_hold();
    mode = 2'b01; pre = 16'd0; last_addr = 10'd2; trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out !== tab[i%3] || sync !== (i % 3 == 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL cont[%0d]: out=%h sync=%b done=%b want %h %b 0",
                 i, out, sync, done, tab[i%3], i % 3 == 0);
      end
      if (i < 8) step();
    end
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out !== 12'h300 || sync !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: out=%h sync=%b busy=%b want 300/0/1",
                 i, out, sync, busy);
      end
    end
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out !== tab[i] || sync !== (i == 0)) begin
        errors++;
        $display("FAIL resume[%0d]: out=%h sync=%b want %h %b",
                 i, out, sync, tab[i], i == 0);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (out !== 12'h300 || busy !== 1'b0 || sync !== 1'b0) begin
      errors++;
      $display("FAIL stop: out=%h busy=%b sync=%b want 300/0/0", out, busy, sync);
    end
    step();
    checks++;
    if (out !== 12'h300 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: out=%h busy=%b want 300/0", out, busy);
    end
  endtask

  task automatic test_restart();
    int ndone;
    mode = 2'b10; pre = 16'd1; last_addr = 10'd3; trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step(); step(); step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_gap: done=%b busy=%b want 0/1", done, busy);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out !== tab[i/2] || sync !== (i == 0) || done !== (i == 7)) begin
        errors++;
        $display("FAIL restart[%0d]: out=%h sync=%b done=%b want %h %b %b",
                 i, out, sync, done, tab[i/2], i == 0, i == 7);
      end
      step();
    end
    trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step(); step();
    stop = 1'b1; trig = 1'b1;
    step();
    stop = 1'b0; trig = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_trig_busy: busy=%b want 0", busy);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy !== 1'b0) ndone++;
      step();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL stop_trig_quiet: done/busy cycles=%0d want 0", ndone);
    end
  endtask

  task automatic test_direct();
    mode = 2'b00; din = 12'hABC;
    step();
    checks++;
    if (out !== 12'hABC) begin
      errors++;
      $display("FAIL direct_abc: out=%h want abc", out);
    end
    din = 12'h123;
    step();
    checks++;
    if (out !== 12'h123) begin
      errors++;
      $display("FAIL direct_123: out=%h want 123", out);
    end
    mode = 2'b10; pre = 16'd0; last_addr = 10'd3; trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step();
    checks++;
    if (out !== 12'h100 || sync !== 1'b1) begin
      errors++;
      $display("FAIL direct_pre_run: out=%h sync=%b want 100/1", out, sync);
    end
    mode = 2'b00; din = 12'h055;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out !== 12'h055 || busy !== 1'b0 || sync !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL direct_abort[%0d]: out=%h busy=%b sync=%b done=%b want 055/0/0/0",
                 i, out, busy, sync, done);
      end
    end
  endtask

  task automatic test_reset_write();
    logic [11:0] exp [6] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h100, 12'h222};
    mode = 2'b01; pre = 16'd0; last_addr = 10'd3; trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out !== 12'h000 || busy !== 1'b0 || sync !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out=%h busy=%b sync=%b want 000/0/0", out, busy, sync);
    end
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 10'd1; wr_data = 12'h222;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out !== exp[i] || sync !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL replay_write[%0d]: out=%h sync=%b want %h %b",
                 i, out, sync, exp[i], i % 4 == 0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous_hold();
    test_restart();
    test_direct();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
